store_drain_ctrl: RTL and testbench

Controller that sequences draining of the store buffer and shares the D$ store port between the store buffer and the AMO unit. It sits between the commit stage, the store buffer, the AMO unit and the D$ store request port. On a fence or AMO it blocks new commits into the store buffer and waits until the buffer has drained. For an AMO it then hands the D$ port to the AMO unit until the AMO completes. It also keeps a drain-cycle performance count and a sticky drain-timeout flag.

---
 rtl/store_drain_ctrl.sv | 151 +++++++++++++++
 tb/tb_store_drain_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_drain_ctrl.sv
// Store-buffer drain sequencer for fences and AMOs.
// Also arbitrates the D$ store port between store buffer and AMO unit.
module store_drain_ctrl #(
  parameter int unsigned TIMEOUT = 1024,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             fence_req_i,
  output logic             fence_ack_o,
  input  logic             amo_req_i,
  output logic             amo_gnt_o,
  input  logic             amo_done_i,
  input  logic             sb_req_i,
  output logic             sb_gnt_o,
  input  logic             sb_empty_i,
  input  logic             sb_no_st_pending_i,
  output logic             sb_stall_o,
  output logic             dc_req_o,
  input  logic             dc_gnt_i,
  output logic             sel_amo_o,
  output logic             busy_o,
  output logic             drain_timeout_o,
  output logic [CNT_W-1:0] drain_cycles_o
);

  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FDRAIN = 3'd1;
  localparam logic [2:0] S_ADRAIN = 3'd2;
  localparam logic [2:0] S_AREQ   = 3'd3;
  localparam logic [2:0] S_AWAIT  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic             ack_q, ack_d;
  logic             to_q, to_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;

  logic st_idle, st_fd, st_ad, st_areq, st_await;
  logic in_drain;

  assign st_idle  = (state_q == S_IDLE);
  assign st_fd    = (state_q == S_FDRAIN);
  assign st_ad    = (state_q == S_ADRAIN);
  assign st_areq  = (state_q == S_AREQ);
  assign st_await = (state_q == S_AWAIT);
  assign in_drain = st_fd | st_ad;

  // flush only aborts the speculative drain phases
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (fence_req_i)    state_d = S_FDRAIN;
        else if (amo_req_i) state_d = S_ADRAIN;
      end
      S_FDRAIN: begin
        if (flush_i || sb_no_st_pending_i)
          state_d = S_IDLE;
      end
      S_ADRAIN: begin
        if (flush_i || !amo_req_i) state_d = S_IDLE;
        else if (sb_empty_i)       state_d = S_AREQ;
      end
      S_AREQ: begin
        if (amo_req_i && dc_gnt_i)
          state_d = S_AWAIT;
      end
      S_AWAIT: begin
        if (amo_done_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    dc_req_o  = sb_req_i;
    sb_gnt_o  = dc_gnt_i;
    amo_gnt_o = 1'b0;
    sel_amo_o = 1'b0;
    unique case (1'b1)
      st_areq: begin
        sel_amo_o = 1'b1;
        dc_req_o  = amo_req_i;
        amo_gnt_o = dc_gnt_i;
        sb_gnt_o  = 1'b0;
      end
      st_await: begin
        sel_amo_o = 1'b1;
        dc_req_o  = 1'b0;
        sb_gnt_o  = 1'b0;
      end
      default: ;
    endcase
  end

  assign busy_o     = ~st_idle;
  assign sb_stall_o = ~st_idle;

  assign ack_d = st_fd & ~flush_i & sb_no_st_pending_i;

  // per-drain counter idles at zero so every entry starts fresh
  always_comb begin
    tcnt_d = '0;
    if (in_drain) begin
      tcnt_d = tcnt_q;
      if (tcnt_q != '1)
        tcnt_d = tcnt_q + TW'(1);
    end
  end

  assign to_d = to_q |
    (in_drain & (tcnt_q == TW'(TIMEOUT - 1)));

  always_comb begin
    cyc_d = cyc_q;
    if (in_drain && cyc_q != '1)
      cyc_d = cyc_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ack_q   <= 1'b0;
      to_q    <= 1'b0;
      cyc_q   <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      to_q    <= to_d;
      cyc_q   <= cyc_d;
      tcnt_q  <= tcnt_d;
    end
  end

  assign fence_ack_o     = ack_q;
  assign drain_timeout_o = to_q;
  assign drain_cycles_o  = cyc_q;

  a_fence_idle: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    fence_req_i |-> !busy_o);
  a_done_wait: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    amo_done_i |-> st_await);

endmodule

// File: tb/tb_store_drain_ctrl.sv
// Bench for store_drain_ctrl: vector table, directed corners,
// and random traffic against a transaction-level model.
module tb_store_drain_ctrl;

  localparam int TO   = 8;
  localparam int CW   = 6;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic flush, fence, amo, done, sbreq, empty, nsp, gnt;
  logic ack_o, amo_gnt_o, sb_gnt_o, stall_o, dc_req_o;
  logic sel_o, busy_o, to_o;
  logic [CW-1:0] cyc_o;

  store_drain_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush),
    .fence_req_i(fence), .fence_ack_o(ack_o),
    .amo_req_i(amo), .amo_gnt_o(amo_gnt_o),
    .amo_done_i(done), .sb_req_i(sbreq),
    .sb_gnt_o(sb_gnt_o), .sb_empty_i(empty),
    .sb_no_st_pending_i(nsp), .sb_stall_o(stall_o),
    .dc_req_o(dc_req_o), .dc_gnt_i(gnt),
    .sel_amo_o(sel_o), .busy_o(busy_o),
    .drain_timeout_o(to_o), .drain_cycles_o(cyc_o)
  );

  always #5 clk = ~clk;

  typedef enum int {P_IDLE, P_FENCE, P_ADRAIN, P_AREQ, P_AWAIT} ph_t;

  ph_t m_ph;
  bit  m_ack, m_to;
  int  m_cyc, m_run;
  int  n_run = 0;
  int  n_fail = 0;

  typedef struct {
    bit f, a, d, sr, e, n, g, fl;
    bit x_ack, x_stall, x_sel, x_agnt, x_sgnt, x_dreq;
    int x_cyc;
  } vec_t;

  vec_t vt[14];

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h",
               nm, $time, got, exp);
    end
  endtask

  task automatic set_in(bit f, bit a, bit d, bit sr,
                        bit e, bit n, bit g, bit fl);
    fence = f; amo = a; done = d; sbreq = sr;
    empty = e; nsp = n; gnt = g; flush = fl;
  endtask

  // expected outputs from who owns the port and the phase
  task automatic model_check();
    bit amo_own;
    bit xdreq, xsgnt, xagnt;
    amo_own = (m_ph == P_AREQ) || (m_ph == P_AWAIT);
    xdreq = amo_own ? ((m_ph == P_AREQ) && amo) : sbreq;
    xsgnt = amo_own ? 1'b0 : gnt;
    xagnt = (m_ph == P_AREQ) && gnt;
    chk("busy", busy_o, m_ph != P_IDLE);
    chk("stall", stall_o, m_ph != P_IDLE);
    chk("sel_amo", sel_o, amo_own);
    chk("dc_req", dc_req_o, xdreq);
    chk("sb_gnt", sb_gnt_o, xsgnt);
    chk("amo_gnt", amo_gnt_o, xagnt);
    chk("fence_ack", ack_o, m_ack);
    chk("timeout", to_o, m_to);
    chk("drain_cyc", 32'(cyc_o), m_cyc);
    chk("one_owner", sb_gnt_o & sel_o, 1'b0);
  endtask

  task automatic model_step();
    ph_t nx;
    nx = m_ph;
    m_ack = (m_ph == P_FENCE) && !flush && nsp;
    if (m_ph == P_FENCE || m_ph == P_ADRAIN) begin
      if (m_cyc < MAXC) m_cyc++;
      m_run++;
      if (m_run >= TO) m_to = 1'b1;
    end else begin
      m_run = 0;
    end
    case (m_ph)
      P_IDLE:
        if (fence) nx = P_FENCE;
        else if (amo) nx = P_ADRAIN;
      P_FENCE:
        if (flush || nsp) nx = P_IDLE;
      P_ADRAIN:
        if (flush || !amo) nx = P_IDLE;
        else if (empty) nx = P_AREQ;
      P_AREQ:
        if (amo && gnt) nx = P_AWAIT;
      P_AWAIT:
        if (done) nx = P_IDLE;
      default: nx = P_IDLE;
    endcase
    m_ph = nx;
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_ack = 0; m_to = 0;
    m_cyc = 0; m_run = 0;
  endtask

  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic adv();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst_ni = 1'b0;
    model_reset();
    sample();
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic run_vec(int i);
    sample();
    chk("v_ack", ack_o, vt[i].x_ack);
    chk("v_stall", stall_o, vt[i].x_stall);
    chk("v_busy", busy_o, vt[i].x_stall);
    chk("v_sel", sel_o, vt[i].x_sel);
    chk("v_amo_gnt", amo_gnt_o, vt[i].x_agnt);
    chk("v_sb_gnt", sb_gnt_o, vt[i].x_sgnt);
    chk("v_dc_req", dc_req_o, vt[i].x_dreq);
    chk("v_cyc", 32'(cyc_o), vt[i].x_cyc);
    adv();
  endtask

  initial begin
    // fence, empty buffer
    vt[0]  = '{1,0,0,0,1,1,0,0, 0,0,0,0,0,0, 0};
    vt[1]  = '{0,0,0,0,1,1,0,0, 0,1,0,0,0,0, 0};
    vt[2]  = '{0,0,0,0,1,1,0,0, 1,0,0,0,0,0, 1};
    vt[3]  = '{0,0,0,0,1,1,0,0, 0,0,0,0,0,0, 1};
    // AMO handoff
    vt[4]  = '{0,1,0,1,0,0,0,0, 0,0,0,0,0,1, 0};
    vt[5]  = '{0,1,0,1,0,0,0,0, 0,1,0,0,0,1, 0};
    vt[6]  = '{0,1,0,1,0,0,0,0, 0,1,0,0,0,1, 1};
    vt[7]  = '{0,1,0,1,1,1,0,0, 0,1,0,0,0,1, 2};
    vt[8]  = '{0,1,0,1,1,1,0,0, 0,1,1,0,0,1, 3};
    vt[9]  = '{0,1,0,1,1,1,1,0, 0,1,1,1,0,1, 3};
    vt[10] = '{0,0,0,1,1,1,0,0, 0,1,1,0,0,0, 3};
    vt[11] = '{0,0,0,1,1,1,1,0, 0,1,1,0,0,0, 3};
    vt[12] = '{0,0,1,1,1,1,0,0, 0,1,1,0,0,0, 3};
    vt[13] = '{0,0,0,1,1,1,1,0, 0,0,0,0,1,1, 3};

    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      if (i == 4) do_reset();
      set_in(vt[i].f, vt[i].a, vt[i].d, vt[i].sr,
             vt[i].e, vt[i].n, vt[i].g, vt[i].fl);
      run_vec(i);
    end

    // fence with pending stores, alternating grants
    do_reset();
    set_in(1, 0, 0, 1, 0, 0, 0, 0);
    sample(); adv();
    for (int k = 1; k <= 5; k++) begin
      set_in(0, 0, 0, 1, 0, 0, bit'(k % 2), 0);
      sample();
      chk("pend_sb_gnt", sb_gnt_o, k % 2);
      chk("pend_ack", ack_o, 0);
      adv();
    end
    set_in(0, 0, 0, 1, 0, 1, 0, 0);
    sample(); adv();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("pend_ack7", ack_o, 1);
    chk("pend_cyc7", 32'(cyc_o), 6);
    adv();
    sample();
    chk("pend_ack8", ack_o, 0);
    adv();

    // flush beats drain-done in AMO_DRAIN
    do_reset();
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    sample(); adv();
    set_in(0, 1, 0, 0, 1, 1, 0, 1);
    sample(); adv();
    set_in(0, 0, 0, 0, 1, 1, 0, 0);
    sample();
    chk("flA_busy", busy_o, 0);
    chk("flA_sel", sel_o, 0);
    adv();
    sample();
    chk("flA_sel2", sel_o, 0);
    adv();

    // flush beats drain-done in FENCE_DRAIN
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    sample(); adv();
    set_in(0, 0, 0, 0, 0, 1, 0, 1);
    sample(); adv();
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    sample();
    chk("flF_busy", busy_o, 0);
    chk("flF_ack", ack_o, 0);
    adv();
    sample();
    chk("flF_ack2", ack_o, 0);
    adv();

    // timeout during a long fence drain
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    sample(); adv();
    for (int k = 1; k <= 20; k++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      sample();
      chk("to_rise", to_o, k >= 9);
      adv();
    end
    set_in(0, 0, 0, 0, 0, 1, 0, 0);
    sample(); adv();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    sample();
    chk("to_ack", ack_o, 1);
    chk("to_sticky", to_o, 1);
    chk("to_cyc", 32'(cyc_o), 21);
    adv();
    do_reset();
    chk("to_cleared", to_o, 0);

    // simultaneous fence and AMO: fence first
    set_in(1, 1, 0, 0, 0, 0, 0, 0);
    sample(); adv();
    set_in(0, 1, 0, 0, 0, 1, 0, 0);
    sample();
    chk("sim_busy1", busy_o, 1);
    adv();
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    sample();
    chk("sim_ack", ack_o, 1);
    chk("sim_busy2", busy_o, 0);
    adv();
    set_in(0, 1, 0, 0, 1, 1, 0, 0);
    sample();
    chk("sim_amo_drain", busy_o, 1);
    chk("sim_sel3", sel_o, 0);
    adv();
    set_in(0, 1, 0, 0, 1, 1, 1, 0);
    sample();
    chk("sim_sel4", sel_o, 1);
    adv();
    set_in(0, 0, 1, 0, 1, 1, 0, 0);
    sample(); adv();

    // async reset while in AMO_WAIT
    do_reset();
    set_in(0, 1, 0, 1, 1, 1, 0, 0);
    sample(); adv();
    sample(); adv();
    set_in(0, 1, 0, 1, 1, 1, 1, 0);
    sample(); adv();
    set_in(0, 0, 0, 1, 1, 1, 1, 0);
    sample();
    chk("ar_sel_pre", sel_o, 1);
    adv();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("ar_busy", busy_o, 0);
    chk("ar_stall", stall_o, 0);
    chk("ar_sel", sel_o, 0);
    chk("ar_agnt", amo_gnt_o, 0);
    chk("ar_dc_req", dc_req_o, 1);
    chk("ar_sb_gnt", sb_gnt_o, 1);
    chk("ar_cyc", 32'(cyc_o), 0);
    chk("ar_ack", ack_o, 0);
    @(posedge clk);
    #1;
    do_reset();

    // random traffic against the model
    begin
      bit hold;
      hold = 0;
      for (int k = 0; k < 3000; k++) begin
        if (m_ph == P_AWAIT) hold = 0;
        if (hold && m_ph == P_ADRAIN &&
            $urandom_range(0, 9) == 0)
          hold = 0;
        else if (!hold && m_ph != P_AREQ &&
                 m_ph != P_AWAIT &&
                 $urandom_range(0, 4) == 0)
          hold = 1;
        flush = ($urandom_range(0, 7) == 0);
        sbreq = $urandom_range(0, 1);
        gnt   = $urandom_range(0, 1);
        empty = ($urandom_range(0, 3) == 0);
        nsp   = empty | ($urandom_range(0, 3) == 0);
        fence = (m_ph == P_IDLE) &&
                ($urandom_range(0, 5) == 0);
        amo   = hold;
        done  = (m_ph == P_AWAIT) &&
                ($urandom_range(0, 2) == 0);
        sample();
        adv();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
